// File: rtl/vector_fixed_converter.sv
// Converts four bfloat16 lanes to signed 16-bit fixed point, one lane per clock.
// Define VECTOR_FIXED_SAT_EN to saturate on overflow; otherwise results wrap.
module vector_fixed_converter #(
  parameter int FRAC_BITS = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] in_vector_val,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [63:0] out_vector_val,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  // Shift amount k = exponent - 134 + FRAC_BITS, folded into one constant bias.
  localparam logic signed [9:0] K_BIAS = 10'(134 - FRAC_BITS);

  state_t      r_state;
  state_t      w_nextState;
  logic [1:0]  r_lane;
  logic [63:0] r_capture;
  logic [63:0] r_result;
  logic [3:0]  r_ovf;

  logic [15:0]       w_laneIn;
  logic              w_sign;
  logic [7:0]        w_expo;
  logic [7:0]        w_mant;
  logic signed [9:0] w_shift;
  logic [9:0]        w_rshAmt;
  logic [31:0]       w_mag;
  logic              w_bigShift;
  logic              w_magOvf;
  logic [15:0]       w_wrap;
  logic [15:0]       w_laneOut;
  logic              w_laneOvf;

  assign w_laneIn = r_capture[{r_lane, 4'b0000} +: 16];
  assign w_sign   = w_laneIn[15];
  assign w_expo   = w_laneIn[14:7];
  assign w_mant   = {1'b1, w_laneIn[6:0]};
  assign w_shift  = $signed({2'b00, w_expo}) - K_BIAS;

  // Left shifts of 16+ always overflow and leave zero in the low 16 bits.
  always_comb begin
    w_mag      = '0;
    w_bigShift = 1'b0;
    w_rshAmt   = '0;
    if (w_shift >= 10'sd0) begin
      if (w_shift > 10'sd15) begin
        w_bigShift = 1'b1;
      end else begin
        w_mag = {24'd0, w_mant} << w_shift[3:0];
      end
    end else begin
      w_rshAmt = 10'(-w_shift);
      if (w_rshAmt < 10'd16) begin
        w_mag = {24'd0, w_mant} >> w_rshAmt[3:0];
      end
    end
  end

  // Negative results may reach 32768 in magnitude without overflowing.
  assign w_magOvf = w_bigShift | (w_sign ? (w_mag > 32'd32768) : (w_mag > 32'd32767));
  assign w_wrap   = w_sign ? (~w_mag[15:0] + 16'd1) : w_mag[15:0];

  always_comb begin
    w_laneOut = '0;
    w_laneOvf = 1'b0;
    if (w_expo == 8'd0) begin
      w_laneOut = '0;
      w_laneOvf = 1'b0;
    end else if (w_expo == 8'hFF) begin
      w_laneOvf = 1'b1;
`ifdef VECTOR_FIXED_SAT_EN
      w_laneOut = w_sign ? 16'h8000 : 16'h7FFF;
`else
      w_laneOut = '0;
`endif
    end else begin
      w_laneOvf = w_magOvf;
`ifdef VECTOR_FIXED_SAT_EN
      w_laneOut = w_magOvf ? (w_sign ? 16'h8000 : 16'h7FFF) : w_wrap;
`else
      w_laneOut = w_wrap;
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Outputs are gated by DONE so partially converted vectors never appear.
  always_comb begin
    w_nextState    = r_state;
    in_ready       = 1'b0;
    out_valid      = 1'b0;
    out_vector_val = '0;
    out_ovf        = '0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_nextState = CONV;
        end
      end
      CONV: begin
        if (r_lane == 2'd3) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        out_valid      = 1'b1;
        out_vector_val = r_result;
        out_ovf        = r_ovf;
        if (out_ready) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_capture <= '0;
      r_lane    <= '0;
      r_result  <= '0;
      r_ovf     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_capture <= in_vector_val;
            r_lane    <= '0;
            r_result  <= '0;
            r_ovf     <= '0;
          end
        end
        CONV: begin
          r_result[{r_lane, 4'b0000} +: 16] <= w_laneOut;
          r_ovf[r_lane]                     <= w_laneOvf;
          r_lane                            <= r_lane + 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
